// File: rtl/alu_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_mult_sequencer
// Description : Multi-cycle shift-and-add multiplier controller. Drives the
//               shared 8-bit ALU (ADD / FORWARD / SHIFT) to form an 8-bit,
//               mod-256 unsigned product of two 8-bit operands.
//               Optional feature macro: ALU_MULT_EARLY_EXIT_EN. When it is
//               defined, the job finishes as soon as the shifted multiplier
//               reaches zero (ALU_ZERO in SHR).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mult_sequencer #(
  // Number of multiplier bits processed; legal range 1..8.
  parameter int STEPS = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] multiplicand_i,
  input  logic [7:0] multiplier_i,
  input  logic [7:0] alu_result_i,
  input  logic       alu_zero_i,
  output logic [7:0] alu_data1_o,
  output logic [7:0] alu_data2_o,
  output logic [2:0] alu_select_o,
  output logic       alu_shift_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] product_o
);

  // ALU select encodings
  localparam logic [2:0] c_SEL_FWD   = 3'b000;
  localparam logic [2:0] c_SEL_ADD   = 3'b001;
  localparam logic [2:0] c_SEL_SHIFT = 3'b100;

  // Shift direction encodings
  localparam logic c_SHIFT_LEFT  = 1'b0;
  localparam logic c_SHIFT_RIGHT = 1'b1;

  // Step counter value at which the final SHR step ends the job
  localparam logic [3:0] c_LAST_CNT = 4'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic       done_q, done_d;

  // High when the current SHR step should be the last one
  logic       w_last_step;

`ifdef ALU_MULT_EARLY_EXIT_EN
  // Shifted multiplier is zero: every remaining ADD step would be skipped,
  // so finishing now gives the same product.
  assign w_last_step = (cnt_q == c_LAST_CNT) || alu_zero_i;
`else
  // Zero flag is not needed when the full step count always runs.
  logic w_unused_zero;
  assign w_unused_zero = alu_zero_i;
  assign w_last_step   = (cnt_q == c_LAST_CNT);
`endif

  // State and datapath registers; asynchronous reset abandons any job
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      acc_q     <= 8'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      cnt_q     <= 4'd0;
      product_q <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // Next-state and register-update decode; ALU result is captured at the
  // edge that ends each step
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = 8'd0;
          a_d     = multiplicand_i;
          b_d     = multiplier_i;
          cnt_d   = 4'd0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        // Partial product only accumulates when the current multiplier bit is set
        if (b_q[0]) begin
          acc_d = alu_result_i;
        end
        state_d = S_SHL;
      end
      S_SHL: begin
        a_d     = alu_result_i;
        state_d = S_SHR;
      end
      S_SHR: begin
        b_d   = alu_result_i;
        cnt_d = cnt_q + 4'd1;
        if (w_last_step) begin
          state_d = S_FIN;
        end else begin
          state_d = S_ADD;
        end
      end
      S_FIN: begin
        product_d = acc_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore ALU drive decode: depends only on state and registers
  always_comb begin
    alu_select_o = c_SEL_FWD;
    alu_data1_o  = 8'd0;
    alu_data2_o  = 8'd0;
    alu_shift_o  = c_SHIFT_LEFT;

    case (state_q)
      S_ADD: begin
        if (b_q[0]) begin
          alu_select_o = c_SEL_ADD;
          alu_data1_o  = acc_q;
          alu_data2_o  = a_q;
        end
      end
      S_SHL: begin
        alu_select_o = c_SEL_SHIFT;
        alu_shift_o  = c_SHIFT_LEFT;
        alu_data1_o  = a_q;
        alu_data2_o  = 8'd1;
      end
      S_SHR: begin
        alu_select_o = c_SEL_SHIFT;
        alu_shift_o  = c_SHIFT_RIGHT;
        alu_data1_o  = b_q;
        alu_data2_o  = 8'd1;
      end
      default: begin
        alu_select_o = c_SEL_FWD;
      end
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mult_sequencer
// Description : Directed self-checking bench for alu_mult_sequencer with a
//               behavioural model of the shared ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mult_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [2:0] alu_select;
  logic       alu_shift;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mult_sequencer #(.STEPS(8)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .multiplicand_i (mcand),
    .multiplier_i   (mplier),
    .alu_result_i   (alu_result),
    .alu_zero_i     (alu_zero),
    .alu_data1_o    (alu_data1),
    .alu_data2_o    (alu_data2),
    .alu_select_o   (alu_select),
    .alu_shift_o    (alu_shift),
    .busy_o         (busy),
    .done_o         (done),
    .product_o      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the shared combinational ALU
  always_comb begin
    case (alu_select)
      3'b001:  alu_result = alu_data1 + alu_data2;
      3'b100:  alu_result = alu_shift ? (alu_data1 >> alu_data2) : (alu_data1 << alu_data2);
      default: alu_result = alu_data1;
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected DONE edge for the build in use
  function automatic int exp_edge(input int full_lat, input int early_lat);
`ifdef ALU_MULT_EARLY_EXIT_EN
    return early_lat;
`else
    return full_lat;
`endif
  endfunction

  // Run one job; optionally pulse START with other operands mid-job, or
  // leave START high at the end so the next job is accepted back-to-back.
  task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_p, input int exp_n, input logic [7:0] exp_mask,
                         input bit glitch, input bit hold);
    int         edge_n;
    int         busy_cnt;
    logic [7:0] mask;
    bit         seen;
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    edge_n = 0; busy_cnt = 0; mask = 8'd0; seen = 1'b0;
    while (!seen && edge_n < 60) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if ((edge_n % 3) == 0 && (edge_n / 3) < 8 && busy && alu_select == 3'b001)
          mask[edge_n / 3] = 1'b1;
        if (glitch && edge_n == 5) begin
          start = 1'b1; mcand = 8'd200; mplier = 8'd77;
        end
        if (glitch && edge_n == 6) start = 1'b0;
        @(posedge clk); #1;
        edge_n++;
      end
    end
    check_eq({tag, "_done_edge"}, edge_n, exp_n);
    check_eq({tag, "_busy_cycles"}, busy_cnt, exp_n);
    check_eq({tag, "_product"}, {24'd0, product}, {24'd0, exp_p});
    check_eq({tag, "_add_mask"}, {24'd0, mask}, {24'd0, exp_mask});
    if (!hold) begin
      check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_product_hold"}, {24'd0, product}, {24'd0, exp_p});
    end
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = 8'd0;
    mplier = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_product", {24'd0, product}, 32'd0);
    check_eq("rst_done",    {31'd0, done}, 32'd0);
    check_eq("rst_busy",    {31'd0, busy}, 32'd0);
    check_eq("rst_drive",   {alu_select, alu_shift, alu_data1, alu_data2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job("m13x11",  8'd13,  8'd11,  8'h8F, exp_edge(25, 13), 8'h0B, 1'b0, 1'b0);
    run_job("m255x255", 8'd255, 8'd255, 8'h01, exp_edge(25, 25), 8'hFF, 1'b0, 1'b0);
    run_job("m16x16",  8'd16,  8'd16,  8'h00, exp_edge(25, 16), 8'h10, 1'b0, 1'b0);
    run_job("m5Ax0",   8'h5A,  8'd0,   8'h00, exp_edge(25, 4),  8'h00, 1'b0, 1'b0);
    run_job("m3x5",    8'd3,   8'd5,   8'd15, exp_edge(25, 10), 8'h05, 1'b0, 1'b0);
    run_job("m0x7",    8'd0,   8'd7,   8'h00, exp_edge(25, 10), 8'h07, 1'b0, 1'b0);

    // START while busy must not disturb the running job
    run_job("glitch",  8'd13,  8'd11,  8'h8F, exp_edge(25, 13), 8'h0B, 1'b1, 1'b0);

    // START held high: next job accepted on the edge right after the DONE edge
    run_job("hold1",   8'd3,   8'd5,   8'd15, exp_edge(25, 10), 8'h05, 1'b0, 1'b1);
    mcand  = 8'd7;
    mplier = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("hold_busy_next", {31'd0, busy}, 32'd1);
    check_eq("hold_done_clear", {31'd0, done}, 32'd0);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("hold2_done_edge", n, exp_edge(25, 13));
    check_eq("hold2_product", {24'd0, product}, 32'h3F);

    // Asynchronous reset in the middle of the SHL step
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'd13;
    mplier = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    check_eq("pre_rst_shl_sel", {29'd0, alu_select}, 32'd4);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",    {31'd0, busy}, 32'd0);
    check_eq("mid_rst_product", {24'd0, product}, 32'd0);
    check_eq("mid_rst_drive",   {alu_select, alu_shift, alu_data1, alu_data2}, 32'd0);
    @(posedge clk); #1;
    check_eq("mid_rst_done",    {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job("m7x9",    8'd7,   8'd9,   8'h3F, exp_edge(25, 13), 8'h09, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
Multi-cycle controller that computes an 8-bit (mod 256) unsigned product by sequencing the shared 8-bit ALU through shift-and-add steps. The ALU provides ADD (SELECT=001), FORWARD (SELECT=000) and SHIFT (SELECT=100; ALU_SHIFT=0 selects left, 1 selects right).
- Owns the ALU operand/select lines while BUSY.
- Captures ALU_RESULT at the clock edge that ends each step.
- Sits beside the CPU control unit and serves a future MUL opcode.

Parameters:
STEPS, 8, number of multiplier bits processed (legal range 1..8)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
START  input  1  request; sampled only in IDLE
MULTIPLICAND  input  8  operand A, captured on accepted START
MULTIPLIER  input  8  operand B, captured on accepted START
ALU_RESULT  input  8  ALU RESULT bus
ALU_ZERO  input  1  ALU ZERO flag
ALU_DATA1  output  8  ALU DATA1 drive
ALU_DATA2  output  8  ALU DATA2 drive
ALU_SELECT  output  3  ALU SELECT drive
ALU_SHIFT  output  1  ALU shift direction (0 = left, 1 = right)
BUSY  output  1  high in every non-IDLE state
DONE  output  1  registered, one-cycle completion pulse
PRODUCT  output  8  registered result; held until the next completion

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - ACC, A, B, CNT, PRODUCT and DONE clear to 0.
  - ALU drives return to the idle drive.
  - Reset mid-operation abandons the job with no DONE and PRODUCT=0.
- Idle drive: ALU_SELECT=000, ALU_DATA1=0, ALU_DATA2=0, ALU_SHIFT=0.
- ALU drives are Moore outputs decoded from the state and registers only.
- Timing constraint: the ALU is combinational with up to 2 units (ADD) or 1 unit + mux (shift) of delay, so the CLK period must be at least 8 time units.
- Internal registers: ACC[7:0], A[7:0], B[7:0], CNT[3:0].
- States and transitions:
  - IDLE:
    - BUSY=0.
    - On START=1: ACC<=0, A<=MULTIPLICAND, B<=MULTIPLIER, CNT<=0, then go to ADD.
  - ADD:
    - If B[0]=1: drive SELECT=001, DATA1=ACC, DATA2=A; ACC<=ALU_RESULT at the edge.
    - Else: idle drive; ACC holds.
    - Always 1 cycle, then go to SHL.
  - SHL:
    - Drive SELECT=100, SHIFT=0, DATA1=A, DATA2=8'd1.
    - A<=ALU_RESULT, then go to SHR.
  - SHR:
    - Drive SELECT=100, SHIFT=1, DATA1=B, DATA2=8'd1.
    - B<=ALU_RESULT, CNT<=CNT+1.
    - Go to FIN if CNT==STEPS-1, else go to ADD.
  - FIN:
    - PRODUCT<=ACC, DONE<=1 (registered; visible the cycle after the FIN edge).
    - Go to IDLE.
  - DONE clears on the next edge.
- Latency:
  - With the edge sampling START as edge 0, DONE rises after edge 3*STEPS+1 (25 for STEPS=8).
  - BUSY is high for 3*STEPS+1 cycles.
- Arithmetic:
  - All sums wrap mod 256; no carry or overflow output.
  - The shifted-out bit of A is discarded.
- Boundary conditions:
  - START while BUSY: ignored; operands are not re-sampled.
  - START held high continuously: a new job is accepted in the first IDLE cycle after FIN, so DONE pulses and the next BUSY are back-to-back.
  - MULTIPLIER=0 or MULTIPLICAND=0: full latency, PRODUCT=0.
  - ALU_ZERO is ignored unless the optional feature below is compiled in.

Optional Feature:
- Macro: ALU_MULT_EARLY_EXIT_EN.
- When defined:
  - In SHR, if ALU_ZERO=1 (shifted B is 0), go to FIN regardless of CNT.
  - Latency becomes 3*k+1, where k = max(1, index of the highest set bit of MULTIPLIER + 1), capped at STEPS.
- When undefined:
  - ALU_ZERO is unused.
  - Latency is always 3*STEPS+1.

Test Plan:
1. RESET=0 then release; START=1 with A=13, B=11 → BUSY for 25 cycles; DONE pulses once; PRODUCT=8'h8F; ALU_SELECT sequence shows 001 only in ADD steps 0, 1 and 3.
2. A=255, B=255 → PRODUCT=8'h01 (wrap); A=16, B=16 → PRODUCT=8'h00.
3. A=0x5A, B=0 → DONE after 25 edges (4 edges with ALU_MULT_EARLY_EXIT_EN), PRODUCT=0; idle drive during every ADD step.
4. A=3, B=5 with ALU_MULT_EARLY_EXIT_EN → DONE after edge 10, PRODUCT=15; without the macro → DONE after edge 25, PRODUCT=15.
5. Pulse START again at cycle 5 of a job with different operands → ignored; result matches the first operands. Hold START high → second job starts the cycle after FIN.
6. Assert RESET low asynchronously mid-SHL → all outputs 0 immediately; no DONE; a new START after release completes normally (7*9 → 8'h3F).
